// File: rtl/dual_issue_decode_queue.sv
// Two-wide instruction queue and MIPS decoder between fetch and issue.
// Holds up to DEPTH fetched {instr, pc} entries and decodes the two oldest.
// Issues 0, 1 or 2 instructions per cycle under a single backend ready.
// Optional feature macro DUAL_ISSUE_EN: when defined, slot 1 may issue
// alongside slot 0 subject to the pairing rules; when undefined the queue
// issues at most one instruction per cycle and slot 1 is held invalid.
module dual_issue_decode_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [1:0]  in_valid,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    output logic        in_ready,
    output logic [1:0]  out_valid,
    output logic [31:0] out_instr0,
    output logic [31:0] out_instr1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [24:0] out_ctrl0,
    output logic [24:0] out_ctrl1,
    input  logic        out_ready
);

    localparam logic [3:0] ALU_NONE = 4'd0,  ALU_ADD  = 4'd1,  ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3,  ALU_SUBU = 4'd4,  ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6,  ALU_XOR  = 4'd7,  ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9,  ALU_SLTU = 4'd10, ALU_SLL  = 4'd11;
    localparam logic [3:0] ALU_SRL  = 4'd12, ALU_SRA  = 4'd13, ALU_LUI  = 4'd14;
    localparam logic [3:0] ALU_HILO = 4'd15;

    localparam logic [PTR_W-1:0] PTR_ONE     = 1;
    localparam logic [PTR_W:0]   CNT_ENQ_MAX = (PTR_W+1)'(DEPTH - 2);

    // Decode one instruction word into the packed control word.
    function automatic logic [24:0] f_decode(input logic [31:0] ins);
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, dst;
        logic [3:0] alu;
        logic rw, imm, sx, mr, mw, m2r, hw, h2r, cw, c2r, mfc, brk, sys, ert, ri, br;
        logic [24:0] res;
        op = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        alu = ALU_NONE; dst = 5'd0;
        rw = 1'b0; imm = 1'b0; sx = 1'b1; mr = 1'b0; mw = 1'b0; m2r = 1'b0;
        hw = 1'b0; h2r = 1'b0; cw = 1'b0; c2r = 1'b0; mfc = 1'b0;
        brk = 1'b0; sys = 1'b0; ert = 1'b0; ri = 1'b0; br = 1'b0;
        case (op)
            6'h00: begin
                dst = rd;
                case (fn)
                    6'h00, 6'h04: begin alu = ALU_SLL;  rw = 1'b1; end
                    6'h02, 6'h06: begin alu = ALU_SRL;  rw = 1'b1; end
                    6'h03, 6'h07: begin alu = ALU_SRA;  rw = 1'b1; end
                    6'h08: br = 1'b1;
                    6'h09: begin br = 1'b1; rw = 1'b1; end
                    6'h0C: sys = 1'b1;
                    6'h0D: brk = 1'b1;
                    6'h10, 6'h12: begin rw = 1'b1; h2r = 1'b1; end
                    6'h11, 6'h13: hw = 1'b1;
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin hw = 1'b1; alu = ALU_HILO; end
                    6'h20: begin alu = ALU_ADD;  rw = 1'b1; end
                    6'h21: begin alu = ALU_ADDU; rw = 1'b1; end
                    6'h22: begin alu = ALU_SUB;  rw = 1'b1; end
                    6'h23: begin alu = ALU_SUBU; rw = 1'b1; end
                    6'h24: begin alu = ALU_AND;  rw = 1'b1; end
                    6'h25: begin alu = ALU_OR;   rw = 1'b1; end
                    6'h26: begin alu = ALU_XOR;  rw = 1'b1; end
                    6'h27: begin alu = ALU_NOR;  rw = 1'b1; end
                    6'h2A: begin alu = ALU_SLT;  rw = 1'b1; end
                    6'h2B: begin alu = ALU_SLTU; rw = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: br = 1'b1;
                    5'h10, 5'h11: begin br = 1'b1; rw = 1'b1; dst = 5'd31; end
                    default: ri = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: br = 1'b1;
            6'h03: begin br = 1'b1; rw = 1'b1; dst = 5'd31; end
            6'h08: begin alu = ALU_ADD;  rw = 1'b1; imm = 1'b1; dst = rt; end
            6'h09: begin alu = ALU_ADDU; rw = 1'b1; imm = 1'b1; dst = rt; end
            6'h0A: begin alu = ALU_SLT;  rw = 1'b1; imm = 1'b1; dst = rt; end
            6'h0B: begin alu = ALU_SLTU; rw = 1'b1; imm = 1'b1; dst = rt; end
            6'h0C: begin alu = ALU_AND;  rw = 1'b1; imm = 1'b1; sx = 1'b0; dst = rt; end
            6'h0D: begin alu = ALU_OR;   rw = 1'b1; imm = 1'b1; sx = 1'b0; dst = rt; end
            6'h0E: begin alu = ALU_XOR;  rw = 1'b1; imm = 1'b1; sx = 1'b0; dst = rt; end
            6'h0F: begin alu = ALU_LUI;  rw = 1'b1; imm = 1'b1; sx = 1'b0; dst = rt; end
            6'h10: begin
                if (ins == 32'h4200_0018) ert = 1'b1;
                else if (rs == 5'h00) begin rw = 1'b1; c2r = 1'b1; mfc = 1'b1; dst = rt; end
                else if (rs == 5'h04) cw = 1'b1;
                else ri = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                alu = ALU_ADDU; rw = 1'b1; imm = 1'b1; mr = 1'b1; m2r = 1'b1; dst = rt;
            end
            6'h28, 6'h29, 6'h2B: begin alu = ALU_ADDU; imm = 1'b1; mw = 1'b1; end
            default: ri = 1'b1;
        endcase
        if (ri)
            res = {6'd0, 1'b1, 18'd0};
        else
            res = {(rw ? dst : 5'd0), br, ri, ert, sys, brk, mfc, c2r, cw,
                   h2r, hw, m2r, mw, mr, sx, imm, rw, alu};
        return res;
    endfunction

    // Serialising bits: hilo_wen, hilo_to_reg, cp0_wen, cp0_to_reg, break, syscall, eret, ri.
    localparam logic [24:0] SER_MASK = 25'h007_BC00;

    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;

    logic [PTR_W-1:0] w_head1, w_tail1;
    logic             w_enq0, w_enq1;
    logic [1:0]       w_n_enq, w_n_deq;
    logic [24:0]      w_ctrl0_raw;

    assign w_head1    = r_head + PTR_ONE;
    assign w_tail1    = r_tail + PTR_ONE;
    assign in_ready   = (r_count <= CNT_ENQ_MAX);
    assign w_enq0     = in_ready & in_valid[0];
    assign w_enq1     = w_enq0 & in_valid[1];
    assign w_n_enq    = {1'b0, w_enq0} + {1'b0, w_enq1};
    assign w_n_deq    = out_ready ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;

    assign out_instr0 = r_instr[r_head];
    assign out_pc0    = r_pc[r_head];
    assign out_instr1 = r_instr[w_head1];
    assign out_pc1    = r_pc[w_head1];

    assign w_ctrl0_raw  = f_decode(r_instr[r_head]);
    assign out_valid[0] = (r_count != '0);
    assign out_ctrl0    = out_valid[0] ? w_ctrl0_raw : 25'd0;

`ifdef DUAL_ISSUE_EN
    logic [24:0] w_ctrl1_raw;
    logic        w_has1, w_raw_haz, w_mem_both, w_serial, w_pair_ok;
    assign w_ctrl1_raw = f_decode(r_instr[w_head1]);
    assign w_has1      = (r_count >= (PTR_W+1)'(2));
    assign w_raw_haz   = w_ctrl0_raw[4] && (w_ctrl0_raw[24:20] != 5'd0) &&
                         ((w_ctrl0_raw[24:20] == out_instr1[25:21]) ||
                          (w_ctrl0_raw[24:20] == out_instr1[20:16]));
    assign w_mem_both  = (w_ctrl0_raw[7] | w_ctrl0_raw[8]) & (w_ctrl1_raw[7] | w_ctrl1_raw[8]);
    assign w_serial    = (|(w_ctrl0_raw & SER_MASK)) | (|(w_ctrl1_raw & SER_MASK));
    assign w_pair_ok   = !w_ctrl1_raw[19] && !w_raw_haz && !w_mem_both && !w_serial;
    assign out_valid[1] = w_has1 && w_pair_ok;
    assign out_ctrl1    = w_has1 ? w_ctrl1_raw : 25'd0;
`else
    assign out_valid[1] = 1'b0;
    assign out_ctrl1    = 25'd0;
`endif

    // Queue storage and pointers: flush empties, otherwise enqueue/dequeue by net change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq0) begin
                r_instr[r_tail] <= in_instr0;
                r_pc[r_tail]    <= in_pc0;
            end
            if (w_enq1) begin
                r_instr[w_tail1] <= in_instr1;
                r_pc[w_tail1]    <= in_pc1;
            end
            r_tail  <= r_tail + PTR_W'(w_n_enq);
            r_head  <= r_head + PTR_W'(w_n_deq);
            r_count <= r_count + (PTR_W+1)'(w_n_enq) - (PTR_W+1)'(w_n_deq);
        end
    end

endmodule

// File: tb/tb_dual_issue_decode_queue.sv
// Directed bench for dual_issue_decode_queue; expectations follow the
// DUAL_ISSUE_EN setting of the build.
module tb_dual_issue_decode_queue;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam logic [31:0] I_ADDU3  = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] I_ORI4   = 32'h34A4_000F; // ori  $4,$5,0x0f
    localparam logic [31:0] I_SUBU6  = 32'h0061_3023; // subu $6,$3,$1
    localparam logic [31:0] I_LW8    = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] I_SW10   = 32'hAD6A_0004; // sw   $10,4($11)
    localparam logic [31:0] I_MULT   = 32'h0022_0018; // mult $1,$2
    localparam logic [31:0] I_ADDU12 = 32'h01AE_6021; // addu $12,$13,$14
    localparam logic [31:0] I_BEQ    = 32'h1022_0004; // beq  $1,$2,4
    localparam logic [31:0] I_BADCP0 = 32'h4200_0019;

    logic        clk = 1'b0;
    logic        resetn, flush, out_ready, in_ready;
    logic [1:0]  in_valid, out_valid;
    logic [31:0] in_instr0, in_instr1, in_pc0, in_pc1;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic [24:0] out_ctrl0, out_ctrl1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_issue_decode_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_ctrl0(out_ctrl0), .out_ctrl1(out_ctrl1), .out_ready(out_ready)
    );

    task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                        input logic [31:0] i1, input logic [31:0] p1);
        in_valid = v; in_instr0 = i0; in_pc0 = p0; in_instr1 = i1; in_pc1 = p1;
        @(negedge clk);
        in_valid = 2'b00;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
        checks++; if (out_ctrl0 !== 25'd0) begin failures++; $display("FAIL reset_ctrl0: got %h want 0", out_ctrl0); end
    endtask

    task automatic test_pair_basic();
        logic [1:0]  va, vb, vc;
        logic [24:0] c0a, c1a, c0b, ori;
        logic [31:0] pa;
        out_ready = 1'b1;
        push(2'b11, I_ADDU3, 32'h0, I_ORI4, 32'h4);
        va = out_valid; c0a = out_ctrl0; c1a = out_ctrl1; pa = out_pc0;
        @(negedge clk);
        vb = out_valid; c0b = out_ctrl0;
        @(negedge clk);
        vc = out_valid;
        ori = DUAL ? c1a : c0b;
        checks++; if (va !== (DUAL ? 2'b11 : 2'b01)) begin failures++; $display("FAIL basic_valid: got %b want %b", va, DUAL ? 2'b11 : 2'b01); end
        checks++; if (pa !== 32'h0) begin failures++; $display("FAIL basic_pc0: got %h want 0", pa); end
        checks++; if (c0a[24:20] !== 5'd3 || c0a[4] !== 1'b1) begin failures++; $display("FAIL basic_addu_ctrl: got %h want dst=3 regwrite=1", c0a); end
        checks++; if (ori[24:20] !== 5'd4 || ori[6:4] !== 3'b011) begin failures++; $display("FAIL basic_ori_ctrl: got %h want dst=4 sign_ex=0 is_imm=1 regwrite=1", ori); end
        checks++; if (vb !== (DUAL ? 2'b00 : 2'b01)) begin failures++; $display("FAIL basic_valid2: got %b want %b", vb, DUAL ? 2'b00 : 2'b01); end
        checks++; if (vc !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_empty: got valid=%b ready=%b want 00/1", vc, in_ready); end
        out_ready = 1'b0;
    endtask

    // Pair whose second instruction must not issue alongside the first.
    task automatic test_lone_pair(input string name, input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        push(2'b11, a, 32'h200, b, 32'h204);
        checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL %s_first: got %b want 01", name, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 2'b01 || out_instr0 !== b) begin failures++; $display("FAIL %s_second: got %b/%h want 01/%h", name, out_valid, out_instr0, b); end
        @(negedge clk);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL %s_drained: got %b want 00", name, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_branch_pair();
        out_ready = 1'b0;
        push(2'b11, I_ADDU12, 32'h300, I_BEQ, 32'h304);
        push(2'b01, I_ADDU12, 32'h308, 32'h0, 32'h0);
        checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL br_slot1_branch: got %b want 01", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== (DUAL ? 2'b11 : 2'b01) || out_instr0 !== I_BEQ) begin failures++; $display("FAIL br_with_delay: got %b/%h want %b/%h", out_valid, out_instr0, DUAL ? 2'b11 : 2'b01, I_BEQ); end
        checks++; if (out_ctrl0[19] !== 1'b1 || out_ctrl0[4] !== 1'b0) begin failures++; $display("FAIL br_ctrl: got %h want is_branch=1 regwrite=0", out_ctrl0); end
        @(negedge clk);
        checks++; if (out_valid !== (DUAL ? 2'b00 : 2'b01)) begin failures++; $display("FAIL br_after: got %b want %b", out_valid, DUAL ? 2'b00 : 2'b01); end
        @(negedge clk);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL br_drained: got %b want 00", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        int got = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(2'b01, I_ADDU12, 32'h100 + 32'(4 * k), 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_at6: got %b want 1", in_ready); end
        push(2'b01, I_ADDU12, 32'h118, 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_at7: got %b want 0", in_ready); end
        push(2'b11, I_ADDU12, 32'hDEAD, I_ADDU12, 32'hBEEF);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 7; cyc++) begin
            if (out_valid[0]) begin
                checks++; if (out_pc0 !== 32'h100 + 32'(4 * got)) begin failures++; $display("FAIL drain_pc0: got %h want %h", out_pc0, 32'h100 + 32'(4 * got)); end
                got++;
            end
            if (out_valid[1]) begin
                checks++; if (out_pc1 !== 32'h100 + 32'(4 * got)) begin failures++; $display("FAIL drain_pc1: got %h want %h", out_pc1, 32'h100 + 32'(4 * got)); end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got !== 7) begin failures++; $display("FAIL drain_count: got %0d want 7", got); end
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL drain_empty: got %b want 00", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(2'b11, I_ADDU12, 32'h400, I_ADDU12, 32'h404);
        push(2'b11, I_ADDU12, 32'h408, I_ADDU12, 32'h40C);
        push(2'b01, I_ADDU12, 32'h410, 32'h0, 32'h0);
        checks++; if (out_valid !== (DUAL ? 2'b11 : 2'b01)) begin failures++; $display("FAIL flush_pre: got %b want %b", out_valid, DUAL ? 2'b11 : 2'b01); end
        flush = 1'b1;
        push(2'b11, I_ADDU12, 32'h500, I_ADDU12, 32'h504);
        flush = 1'b0;
        checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty: got valid=%b ready=%b want 00/1", out_valid, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL flush_dropped: got %b want 00", out_valid); end
    endtask

    task automatic test_ri();
        out_ready = 1'b0;
        push(2'b11, I_BADCP0, 32'h600, I_ADDU12, 32'h604);
        checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL ri_alone: got %b want 01", out_valid); end
        checks++; if (out_ctrl0 !== 25'h004_0000) begin failures++; $display("FAIL ri_ctrl: got %h want 0040000", out_ctrl0); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 2'b01 || out_instr0 !== I_ADDU12) begin failures++; $display("FAIL ri_next: got %b/%h want 01/%h", out_valid, out_instr0, I_ADDU12); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push(2'b11, I_ADDU12, 32'h700, I_ADDU12, 32'h704);
        push(2'b11, I_ADDU12, 32'h708, I_ADDU12, 32'h70C);
        resetn = 1'b0;
        #2;
        checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset: got valid=%b ready=%b want 00/1", out_valid, in_ready); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL mid_reset_after: got %b want 00", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 2'b00;
        in_instr0 = '0; in_instr1 = '0; in_pc0 = '0; in_pc1 = '0;
        @(negedge clk);
        test_reset();
        test_pair_basic();
        test_lone_pair("raw", I_ADDU3, I_SUBU6);
        test_lone_pair("mem", I_LW8, I_SW10);
        test_lone_pair("hilo", I_MULT, I_ADDU12);
        test_lone_pair("ri_slot1", I_ADDU12, I_BADCP0);
        test_branch_pair();
        test_fill_drain();
        test_flush();
        test_ri();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
